// File: rtl/spi_byte_if.sv
// Command-side byte interface between the sequencer (master) and the SPI byte engine (slave).
// The producer waits for ~busy before each write; recv_valid marks a fresh byte_recv.
interface spi_byte_if;
  logic       write;
  logic [7:0] byte_send;
  logic       busy;
  logic [7:0] byte_recv;
  logic       recv_valid;

  modport master (
    output write, byte_send,
    input  busy, byte_recv, recv_valid
  );

  modport slave (
    input  write, byte_send,
    output busy, byte_recv, recv_valid
  );
endinterface

// File: rtl/spi_byte_master.sv
// SPI mode-0 byte master: one byte per write, busy for 16*CLK_DIV cycles, cs_L held CS_IDLE cycles after.
// Writes are only accepted when not shifting; the producer is expected to wait for ~busy.
module spi_byte_master #(
  parameter int CLK_DIV = 4,
  parameter int CS_IDLE = 16
) (
  input  logic       clk,
  input  logic       rst_L,
  spi_byte_if.slave  cmd,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       cs_L
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SHIFT_LO = 2'd1;
  localparam logic [1:0] SHIFT_HI = 2'd2;
  localparam logic [1:0] HOLD     = 2'd3;

  localparam int DIV_W  = $clog2(CLK_DIV) + 1;
  localparam int IDLE_W = $clog2(CS_IDLE) + 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(CS_IDLE - 1);

  logic [1:0]        state;
  logic [DIV_W-1:0]  div_cnt;
  logic [2:0]        bit_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [6:0]        tx_sr;   // bits still to send after the one on mosi
  logic [7:0]        rx_sr;

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state          <= IDLE;
      div_cnt        <= '0;
      bit_cnt        <= '0;
      idle_cnt       <= '0;
      tx_sr          <= '0;
      rx_sr          <= '0;
      sclk           <= 1'b0;
      mosi           <= 1'b0;
      cs_L           <= 1'b1;
      cmd.busy       <= 1'b0;
      cmd.recv_valid <= 1'b0;
      cmd.byte_recv  <= 8'h00;
    end else begin
      cmd.recv_valid <= 1'b0;
      case (state)
        IDLE, HOLD: begin
          // A write in the final HOLD cycle wins over the cs_L release.
          if (cmd.write) begin
            tx_sr    <= cmd.byte_send[6:0];
            mosi     <= cmd.byte_send[7];
            cmd.busy <= 1'b1;
            cs_L     <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            state    <= SHIFT_LO;
          end else if (state == HOLD) begin
            if (idle_cnt == IDLE_LAST) begin
              cs_L  <= 1'b1;
              state <= IDLE;
            end else begin
              idle_cnt <= idle_cnt + IDLE_W'(1);
            end
          end
        end
        SHIFT_LO: begin
          if (div_cnt == DIV_LAST) begin
            sclk    <= 1'b1;
            rx_sr   <= {rx_sr[6:0], miso};
            div_cnt <= '0;
            state   <= SHIFT_HI;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        SHIFT_HI: begin
          if (div_cnt == DIV_LAST) begin
            sclk    <= 1'b0;
            div_cnt <= '0;
            if (bit_cnt != 3'd7) begin
              bit_cnt <= bit_cnt + 3'd1;
              mosi    <= tx_sr[6];
              tx_sr   <= {tx_sr[5:0], 1'b0};
              state   <= SHIFT_LO;
            end else begin
              cmd.busy       <= 1'b0;
              cmd.byte_recv  <= rx_sr;
              cmd.recv_valid <= 1'b1;
              idle_cnt       <= '0;
              state          <= HOLD;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_byte_master.sv
// Bench for spi_byte_master: transaction-level timing model checked every cycle, plus directed scenarios.
module tb_spi_byte_master;
  localparam int D        = 2;
  localparam int CI       = 4;
  localparam int BUSY_LEN = 16 * D;

  logic clk = 1'b0;
  logic rst_L = 1'b0;
  logic sclk, mosi, miso, cs_L;
  logic loopback = 1'b1;
  logic miso_fix = 1'b0;

  spi_byte_if cmd();

  always #5 clk = ~clk;
  assign miso = loopback ? mosi : miso_fix;

  spi_byte_master #(.CLK_DIV(D), .CS_IDLE(CI)) dut (
    .clk   (clk),
    .rst_L (rst_L),
    .cmd   (cmd),
    .sclk  (sclk),
    .mosi  (mosi),
    .miso  (miso),
    .cs_L  (cs_L)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Model: a byte occupies ages 1..BUSY_LEN (age = edges since the accepting edge),
  // then CI hold cycles with cs_L low, then idle.
  logic       m_idle;
  int         m_age;
  logic [7:0] m_byte, m_rx, m_recv;
  logic       m_mosi_last;

  always @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      m_idle = 1'b1; m_age = 0; m_byte = 8'h00; m_rx = 8'h00; m_recv = 8'h00; m_mosi_last = 1'b0;
    end else begin
      if (!m_idle && m_age >= 1 && m_age <= BUSY_LEN && (m_age % (2 * D)) == D)
        m_rx = {m_rx[6:0], miso};
      if (cmd.write && (m_idle || m_age > BUSY_LEN)) begin
        m_byte = cmd.byte_send;
        m_age  = 1;
        m_idle = 1'b0;
      end else if (!m_idle) begin
        m_age++;
        if (m_age == BUSY_LEN + 1) m_recv = m_rx;
        if (m_age > BUSY_LEN + CI) begin
          m_idle      = 1'b1;
          m_mosi_last = m_byte[0];
        end
      end
    end
  end

  function automatic logic [12:0] expect_outs();
    logic b, v, s, mo, cs;
    b = 1'b0; v = 1'b0; s = 1'b0; mo = m_mosi_last; cs = 1'b1;
    if (!m_idle && m_age <= BUSY_LEN) begin
      b  = 1'b1;
      s  = (((m_age - 1) / D) % 2) == 1;
      mo = m_byte[7 - ((m_age - 1) / (2 * D))];
      cs = 1'b0;
    end else if (!m_idle) begin
      v  = (m_age == BUSY_LEN + 1);
      mo = m_byte[0];
      cs = 1'b0;
    end
    return {b, v, s, mo, cs, m_recv};
  endfunction

  // Per-cycle compare and event monitors, sampled on the falling edge.
  int cyc = 0, n_rise = 0, n_busy = 0, n_valid = 0, n_ff = 0, n_csrise = 0;
  int fall_cyc = 0, rise_cyc = 0;
  logic [7:0] mosi_cap = 8'h00, last_recv = 8'h00;
  logic p_sclk = 1'b0, p_busy = 1'b0, p_cs = 1'b1;

  always @(negedge clk) begin
    cyc++;
    chk($sformatf("outs@cyc%0d", cyc),
        32'({cmd.busy, cmd.recv_valid, sclk, mosi, cs_L, cmd.byte_recv}), 32'(expect_outs()));
    if (sclk && !p_sclk) begin n_rise++; mosi_cap = {mosi_cap[6:0], mosi}; end
    if (cmd.busy) n_busy++;
    if (p_busy && !cmd.busy) fall_cyc = cyc;
    if (cs_L && !p_cs) begin n_csrise++; rise_cyc = cyc; end
    if (cmd.recv_valid) begin
      n_valid++;
      last_recv = cmd.byte_recv;
      if (cmd.byte_recv == 8'hFF) n_ff++;
    end
    p_sclk = sclk; p_busy = cmd.busy; p_cs = cs_L;
  end

  int s_rise, s_busy, s_valid, s_ff, s_csrise;

  task automatic snap();
    s_rise = n_rise; s_busy = n_busy; s_valid = n_valid; s_ff = n_ff; s_csrise = n_csrise;
  endtask

  task automatic send(input logic [7:0] b);
    cmd.byte_send = b;
    cmd.write = 1'b1;
    @(posedge clk); #1;
    cmd.write = 1'b0;
  endtask

  task automatic wait_busy_low(input int maxc);
    int n = 0;
    while (cmd.busy !== 1'b0 && n < maxc) begin @(posedge clk); #1; n++; end
    chk("busy_low_wait", 32'(cmd.busy), 32'd0);
  endtask

  task automatic wait_cs_high(input int maxc);
    int n = 0;
    while (cs_L !== 1'b1 && n < maxc) begin @(posedge clk); #1; n++; end
    chk("cs_high_wait", 32'(cs_L), 32'd1);
    @(negedge clk); #1;
  endtask

  localparam logic [12:0] RESET_OUTS = 13'b0_0_0_0_1_00000000;
  logic [7:0] seq_bytes [4] = '{8'h04, 8'h00, 8'h00, 8'h00};

  initial begin
    cmd.write = 1'b0;
    cmd.byte_send = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", 32'({cmd.busy, cmd.recv_valid, sclk, mosi, cs_L, cmd.byte_recv}), 32'(RESET_OUTS));
    rst_L = 1'b1;
    @(posedge clk); #1;

    // Single byte with loopback.
    snap();
    send(8'hA5);
    wait_cs_high(100);
    chk("a5_busy_cycles", 32'(n_busy - s_busy), 32'd32);
    chk("a5_mosi_bits",   32'(mosi_cap), 32'h0A5);
    chk("a5_sclk_rises",  32'(n_rise - s_rise), 32'd8);
    chk("a5_valid_count", 32'(n_valid - s_valid), 32'd1);
    chk("a5_byte_recv",   32'(last_recv), 32'h0A5);
    chk("a5_cs_delay",    32'(rise_cyc - fall_cyc), 32'd4);

    // Write mid-byte is ignored.
    snap();
    send(8'h96);
    repeat (9) @(posedge clk);
    #1;
    send(8'h3C);
    wait_cs_high(100);
    chk("ign_busy_cycles", 32'(n_busy - s_busy), 32'd32);
    chk("ign_valid_count", 32'(n_valid - s_valid), 32'd1);
    chk("ign_byte_recv",   32'(last_recv), 32'h096);
    chk("ign_mosi_bits",   32'(mosi_cap), 32'h096);

    // Back-to-back bytes, miso tied high.
    loopback = 1'b0;
    miso_fix = 1'b1;
    snap();
    send(8'h01);
    for (int k = 0; k < 4; k++) begin
      wait_busy_low(100);
      send(seq_bytes[k]);
    end
    wait_cs_high(200);
    chk("b2b_sclk_rises", 32'(n_rise - s_rise), 32'd40);
    chk("b2b_valid_count", 32'(n_valid - s_valid), 32'd5);
    chk("b2b_ff_count",   32'(n_ff - s_ff), 32'd5);
    chk("b2b_cs_rises",   32'(n_csrise - s_csrise), 32'd1);
    chk("b2b_busy_cycles", 32'(n_busy - s_busy), 32'd160);
    loopback = 1'b1;

    // Write in the last hold cycle keeps cs_L low.
    snap();
    send(8'h81);
    wait_busy_low(100);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_cs_low", 32'(cs_L), 32'd0);
    send(8'h7E);
    chk("hold_busy_at_edge", 32'(cmd.busy), 32'd1);
    chk("hold_cs_still_low", 32'(cs_L), 32'd0);
    wait_cs_high(100);
    chk("hold_cs_rises",   32'(n_csrise - s_csrise), 32'd1);
    chk("hold_valid_count", 32'(n_valid - s_valid), 32'd2);
    chk("hold_byte_recv",  32'(last_recv), 32'h07E);
    chk("hold_sclk_rises", 32'(n_rise - s_rise), 32'd16);

    // Asynchronous reset mid-byte, then a clean transfer.
    snap();
    send(8'hF0);
    repeat (17) @(posedge clk);
    #2;
    rst_L = 1'b0;
    #1;
    chk("async_reset_outs", 32'({cmd.busy, cmd.recv_valid, sclk, mosi, cs_L, cmd.byte_recv}), 32'(RESET_OUTS));
    @(posedge clk); #1;
    rst_L = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_valid", 32'(n_valid - s_valid), 32'd0);
    snap();
    send(8'h5A);
    wait_cs_high(100);
    chk("post_rst_valid_count", 32'(n_valid - s_valid), 32'd1);
    chk("post_rst_byte_recv",   32'(last_recv), 32'h05A);
    chk("post_rst_mosi_bits",   32'(mosi_cap), 32'h05A);
    chk("post_rst_sclk_rises",  32'(n_rise - s_rise), 32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end
endmodule
